logic_resp_checker: RTL

//  Response-side checker for the bitwise logic units (or_4b and its and/xor siblings).
//  A stimulus source presents operand pairs plus the DUT output. This block:

---
 rtl/logic_resp_checker_if.sv | 24 ++
 rtl/logic_resp_checker.sv | 118 +++++++++++
 2 files changed

// File: rtl/logic_resp_checker_if.sv
// Vector bus between a stimulus source and the response checker.
// The source presents operands, opcode, the unit's result and a last flag;
// the checker answers with in_ready.
interface logic_resp_checker_if #(
   parameter int WIDTH = 4
);
   logic             in_valid;
   logic             in_ready;
   logic             in_last;
   logic [1:0]       op;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic [WIDTH-1:0] dut_out;

   modport master (
      output in_valid, in_last, op, x, y, dut_out,
      input  in_ready
   );

   modport slave (
      input  in_valid, in_last, op, x, y, dut_out,
      output in_ready
   );
endinterface

// File: rtl/logic_resp_checker.sv
// Response checker for the bitwise logic units (OR/AND/XOR/NOR).
// Recomputes each accepted vector's result, compares it one cycle later,
// keeps saturating vector/error counts, latches the first failure and
// reports pass/fail once the final vector has drained through the compare.
module logic_resp_checker #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   logic_resp_checker_if.slave  bus,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [CNT_W-1:0]     vec_count,
   output logic [CNT_W-1:0]     err_count,
   output logic [CNT_W-1:0]     fail_idx,
   output logic [WIDTH-1:0]     fail_exp,
   output logic [WIDTH-1:0]     fail_got
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   // One compare slot: the recomputed result and what the unit produced.
   typedef struct packed {
      logic [WIDTH-1:0] exp;
      logic [WIDTH-1:0] got;
   } cmp_t;

   state_t           state, state_nxt;
   cmp_t             s1;
   // vld_pipe[0]: s1 holds a vector to compare; vld_pipe[1]: a compare
   // happened on the previous edge (used to know the drain is complete).
   logic [1:0]       vld_pipe;
   logic             accept;
   logic             start_ok;
   logic             mismatch;
   logic [WIDTH-1:0] exp_calc;

   assign accept   = bus.in_valid && bus.in_ready;
   assign start_ok = start && ((state == IDLE) || (state == DONE));
   assign mismatch = (s1.exp != s1.got);
   assign pass     = done && (err_count == '0) && (vec_count != '0);

   // Reference result of the unit under check; the NOR inversion stays WIDTH bits.
   always_comb begin
      exp_calc = '0;
      case (bus.op)
         2'b00:   exp_calc = bus.x | bus.y;
         2'b01:   exp_calc = bus.x & bus.y;
         2'b10:   exp_calc = bus.x ^ bus.y;
         default: exp_calc = ~(bus.x | bus.y);
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next state: DRAIN waits until the final vector's compare has landed.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start)                        state_nxt = RUN;
         RUN:     if (accept && bus.in_last)        state_nxt = DRAIN;
         DRAIN:   if (vld_pipe[1] && !vld_pipe[0])  state_nxt = DONE;
         DONE:    if (start)                        state_nxt = RUN;
         default:                                   state_nxt = IDLE;
      endcase
   end

   // State-decoded outputs.
   always_comb begin
      bus.in_ready = (state == RUN);
      busy         = (state == RUN) || (state == DRAIN);
      done         = (state == DONE);
   end

   // Stage 1: capture expected/actual on accept and advance the valid pipe.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_pipe <= '0;
         s1       <= '0;
      end else begin
         vld_pipe <= {vld_pipe[0], accept};
         if (accept) begin
            s1.exp <= exp_calc;
            s1.got <= bus.dut_out;
         end
      end
   end

   // Stage 2: compare, saturating counts, first-failure capture.
   always_ff @(posedge clk) begin
      if (rst || start_ok) begin
         vec_count <= '0;
         err_count <= '0;
         fail_idx  <= '0;
         fail_exp  <= '0;
         fail_got  <= '0;
      end else if (vld_pipe[0]) begin
         if (vec_count != '1) vec_count <= vec_count + 1'b1;
         if (mismatch) begin
            if (err_count != '1) err_count <= err_count + 1'b1;
            // err_count is still zero only before the run's first mismatch.
            if (err_count == '0) begin
               fail_idx <= vec_count;
               fail_exp <= s1.exp;
               fail_got <= s1.got;
            end
         end
      end
   end

endmodule
